// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// nsa_pkg : shared state encoding and slice width for nibble_serial_adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package nsa_pkg;

  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/carr_skip_add.sv
// ============================================================================
// carr_skip_add : 4-bit carry-skip adder slice (ripple chain plus skip mux)
// Revision: 1.0
// ============================================================================
`default_nettype none

module carr_skip_add
  import nsa_pkg::*;
(
  input  logic [NIBW-1:0] a_i,
  input  logic [NIBW-1:0] b_i,
  input  logic            cin_i,
  output logic [NIBW-1:0] sum_o,
  output logic            cout_o
);

  logic [NIBW-1:0] w_p;
  logic [NIBW-1:0] w_g;
  logic [NIBW:0]   w_c;

  assign w_p    = a_i ^ b_i;
  assign w_g    = a_i & b_i;
  assign w_c[0] = cin_i;

  for (genvar i = 0; i < NIBW; i++) begin : g_ripple
    assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
  end

  assign sum_o  = w_p ^ w_c[NIBW-1:0];
  // All-propagate nibble bypasses the ripple chain with the incoming carry.
  assign cout_o = (&w_p) ? cin_i : w_c[NIBW];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder : WIDTH-bit add/sub sequenced one nibble per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              NIB      = WIDTH / NIBW;
  localparam int              CNTW     = $clog2(NIB);
  localparam logic [CNTW-1:0] LAST_NIB = CNTW'(NIB - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              msb_a_q, msb_a_d;
  logic              msb_b_q, msb_b_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [CNTW-1:0]   nib_cnt_q, nib_cnt_d;

  logic [NIBW-1:0]   w_sum;
  logic              w_cout;
  logic [WIDTH-1:0]  w_b_in;

  carr_skip_add u_slice (
    .a_i    (a_sh_q[NIBW-1:0]),
    .b_i    (b_sh_q[NIBW-1:0]),
    .cin_i  (carry_q),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  assign w_b_in = op_sub ? ~b : b;

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    msb_a_d   = msb_a_q;
    msb_b_d   = msb_b_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    nib_cnt_d = nib_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = w_b_in;
          carry_d   = op_sub | cin;
          msb_a_d   = a[WIDTH-1];
          msb_b_d   = w_b_in[WIDTH-1];
          nib_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d    = {{NIBW{1'b0}}, a_sh_q[WIDTH-1:NIBW]};
        b_sh_d    = {{NIBW{1'b0}}, b_sh_q[WIDTH-1:NIBW]};
        sum_d     = {w_sum, sum_q[WIDTH-1:NIBW]};
        carry_d   = w_cout;
        nib_cnt_d = nib_cnt_q + CNTW'(1);
        if (nib_cnt_q == LAST_NIB) begin
          // Top nibble: operand sign bits are compared with the result sign bit.
          cout_d    = w_cout;
          ovf_d     = (msb_a_q == msb_b_q) && (w_sum[NIBW-1] != msb_a_q);
          nib_cnt_d = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      msb_a_q   <= 1'b0;
      msb_b_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      nib_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      msb_a_q   <= msb_a_d;
      msb_b_q   <= msb_b_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// tb_nibble_serial_adder : randomized and directed checks against an
// integer-arithmetic reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain signed/unsigned integer arithmetic, packed as {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int          sa;
    int          sb;
    int          res;
    int unsigned ures;
    logic        c;
    logic        o;
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      res = sa - sb;
      c   = (ma >= mb);
    end else begin
      res  = sa + sb + int'(mcin);
      ures = int'(ma) + int'(mb) + int'(mcin);
      c    = (ures > 32'd65535);
    end
    o = (res > 32767) || (res < -32768);
    return {o, c, res[15:0]};
  endfunction

  // Presents one operand set, waits for out_valid; lat=99 on timeout.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; op_sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] ta;
    logic [15:0] tb;
    logic        tcin;
    logic        tsub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    int   lat;
    v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    foreach (v[i]) begin
      run_op(v[i].ta, v[i].tb, v[i].tcin, v[i].tsub, lat);
      n_vec++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
      end
      n_vec++;
      if ({sum, cout, ovf} !== {v[i].esum, v[i].ecout, v[i].eovf}) begin
        n_err++;
        $display("FAIL directed[%0d] %h %s %h: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, v[i].ta, v[i].tsub ? "-" : "+", v[i].tb, sum, cout, ovf,
                 v[i].esum, v[i].ecout, v[i].eovf);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [17:0] exp_v;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'hFFFF;
      exp_v = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, lat);
      n_vec++;
      if (lat !== 4 || {ovf, cout, sum} !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=%h cout=%b ovf=%b",
                 i, ra, rb, rc, rs, lat, sum, cout, ovf, exp_v[15:0], exp_v[16], exp_v[17]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp_v;
    int          lat;
    exp_v = model(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
    run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({out_valid, in_ready, ovf, cout, sum} !== {1'b1, 1'b0, exp_v}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b sum=%h cout=%b ovf=%b, want vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                 i, out_valid, in_ready, sum, cout, ovf, exp_v[15:0], exp_v[16], exp_v[17]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL backpressure_no_second_op[%0d]: rdy=%b vld=%b, want rdy=1 vld=0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_run: vld=%b rdy=%b sum=%h cout=%b ovf=%b, want vld=0 rdy=1 sum=0000 cout=0 ovf=0",
               out_valid, in_ready, sum, cout, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
    n_vec++;
    if (lat !== 4 || sum !== 16'h1000 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset_add: lat=%0d sum=%h cout=%b, want lat=4 sum=1000 cout=0", lat, sum, cout);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
